// File: rtl/comparator_32bit_d_if.sv
`default_nettype none
// ============================================================================
// Module   : comparator_32bit_d_if
// Brief    : Operand/result bundle for the registered magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
interface comparator_32bit_d_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             greater;
    logic             less;
    logic             equal;
    logic             out_valid;

    modport master (
        output in_valid, a, b,
        input  greater, less, equal, out_valid
    );

    modport slave (
        input  in_valid, a, b,
        output greater, less, equal, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/comparator_32bit_d.sv
`default_nettype none
// ============================================================================
// Module   : comparator_32bit_d
// Brief    : Registered magnitude comparator; slice compare tree merged
//            MSB-first. Define COMPARATOR_SIGNED_EN for two's complement.
// Revision : 1.0 - initial release
// ============================================================================
module comparator_32bit_d #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    comparator_32bit_d_if.slave  bus
);
    localparam int c_nslice = WIDTH / SLICE;

    logic [c_nslice-1:0] w_gt;
    logic [c_nslice-1:0] w_eq;
    logic [c_nslice-1:0] w_cgt;
    logic [c_nslice-1:0] w_ceq;
    logic                w_gt_final;
    logic                w_eq_final;
    logic                w_lt_final;

    logic r_greater;
    logic r_less;
    logic r_equal;
    logic r_out_valid;

    generate
        for (genvar i = 0; i < c_nslice; i++) begin : g_slice
            assign w_gt[i] = bus.a[i*SLICE +: SLICE] >  bus.b[i*SLICE +: SLICE];
            assign w_eq[i] = bus.a[i*SLICE +: SLICE] == bus.b[i*SLICE +: SLICE];
        end
    endgenerate

    // Chain runs from the top slice down; index 0 holds the full-width result.
    assign w_cgt[c_nslice-1] = w_gt[c_nslice-1];
    assign w_ceq[c_nslice-1] = w_eq[c_nslice-1];

    generate
        for (genvar i = 0; i < c_nslice - 1; i++) begin : g_merge
            assign w_cgt[i] = w_cgt[i+1] | (w_ceq[i+1] & w_gt[i]);
            assign w_ceq[i] = w_ceq[i+1] & w_eq[i];
        end
    endgenerate

    assign w_eq_final = w_ceq[0];

`ifdef COMPARATOR_SIGNED_EN
    logic w_sign_diff;
    // Differing sign bits: the non-negative operand wins regardless of magnitude.
    assign w_sign_diff = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    assign w_gt_final  = w_sign_diff ? ~bus.a[WIDTH-1] : w_cgt[0];
`else
    assign w_gt_final  = w_cgt[0];
`endif

    assign w_lt_final = ~w_gt_final & ~w_eq_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_greater   <= 1'b0;
            r_less      <= 1'b0;
            r_equal     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_greater <= w_gt_final;
                r_less    <= w_lt_final;
                r_equal   <= w_eq_final;
            end
        end
    end

    assign bus.greater   = r_greater;
    assign bus.less      = r_less;
    assign bus.equal     = r_equal;
    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_comparator_32bit_d.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparator_32bit_d
// Brief    : Directed-vector bench for comparator_32bit_d.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparator_32bit_d;
    // Flag encoding: {out_valid, greater, less, equal}
    localparam logic [3:0] c_zero = 4'b0000;
    localparam logic [3:0] c_gt   = 4'b1100;
    localparam logic [3:0] c_lt   = 4'b1010;
    localparam logic [3:0] c_eq   = 4'b1001;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    comparator_32bit_d_if #(.WIDTH(32)) bus ();

    comparator_32bit_d #(
        .WIDTH (32),
        .SLICE (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {bus.out_valid, bus.greater, bus.less, bus.equal};
    endfunction

    task automatic check_flags(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_miss++;
            $display("FAIL %s: got %b want %b (out_valid,gt,lt,eq)", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic v);
        @(negedge clk);
        bus.a        = va;
        bus.b        = vb;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", flags(), c_zero);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_flags("idle_after_reset", flags(), c_zero);

        drive(32'h0000_0000, 32'h0000_0000, 1'b1);
        check_flags("zero_eq", flags(), c_eq);
        drive(32'h1234_5679, 32'h1234_5678, 1'b1);
        check_flags("bit0_gt", flags(), c_gt);
        drive(32'h1234_5678, 32'h1234_5679, 1'b1);
        check_flags("bit0_lt", flags(), c_lt);
        drive(32'hABCD_0001, 32'hABCD_0000, 1'b1);
        check_flags("upper_tie_gt", flags(), c_gt);
        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
`ifdef COMPARATOR_SIGNED_EN
        check_flags("ones_vs_zero", flags(), c_lt);
`else
        check_flags("ones_vs_zero", flags(), c_gt);
`endif

        // Asynchronous reset mid-cycle with flags set; must clear before next edge.
        #2;
        rst = 1'b1;
        #1;
        check_flags("async_reset", flags(), c_zero);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_flags("post_reset_idle", flags(), c_zero);

        // Back-to-back stream, then idle to observe hold.
        drive(32'hA82C_77E1, 32'hC1B3_AA91, 1'b1);
        check_flags("b2b_less1", flags(), c_lt);
        drive(32'hDDC2_9912, 32'hDDFC_AA9F, 1'b1);
        check_flags("b2b_less2", flags(), c_lt);
        drive(32'hF9FD_9A93, 32'hC91A_FAF2, 1'b1);
        check_flags("b2b_greater", flags(), c_gt);
        drive(32'h8000_0000, 32'h0000_0001, 1'b1);
`ifdef COMPARATOR_SIGNED_EN
        check_flags("b2b_sign", flags(), c_lt);
`else
        check_flags("b2b_sign", flags(), c_gt);
`endif
        drive(32'h0000_0000, 32'h0000_0000, 1'b1);
        check_flags("b2b_zero", flags(), c_eq);
        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        check_flags("hold1", flags(), 4'b0001);
        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        check_flags("hold2", flags(), 4'b0001);
        drive(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
`ifdef COMPARATOR_SIGNED_EN
        check_flags("sign_pos_neg", flags(), c_gt);
`else
        check_flags("sign_pos_neg", flags(), c_lt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
